// File: rtl/imsic_arb_pkg.sv
// Shared types for the IMSIC access arbiter: FSM states and the captured request.
package imsic_arb_pkg;

  localparam int unsigned RiscvXlen      = 64;
  localparam int unsigned NrVSIntpFilesW = 3;
  localparam int unsigned DefVgeinW      = NrVSIntpFilesW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [1:0]           priv;
    logic [DefVgeinW-1:0] vgein;
    logic [31:0]          addr;
    logic [RiscvXlen-1:0] data;
    logic                 we;
    logic                 claim;
  } imsic_req_t;

endpackage

// File: rtl/imsic_arb_rr.sv
// Round-robin grant: first requester after ptr (wrapping) wins.
module imsic_arb_rr #(
  parameter int unsigned NrReq = 2,
  parameter int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [NrReq-1:0] gnt,
  output logic [IdxW-1:0]  idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= NrReq; i++) begin
      cand = (int'(ptr) + i) % NrReq;
      if (!found && req[cand[IdxW-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IdxW-1:0]]   = 1'b1;
        idx                   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/imsic_access_arbiter.sv
// Arbitrates NrReq requesters onto one IMSIC port: IDLE -> ISSUE -> RESP, 3 cycles/access.
module imsic_access_arbiter
  import imsic_arb_pkg::*;
#(
  parameter int unsigned NrReq  = 2,
  parameter int unsigned XLEN   = RiscvXlen,
  parameter int unsigned VgeinW = DefVgeinW
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrReq-1:0]              req_valid_i,
  output logic [NrReq-1:0]              req_ready_o,
  input  logic [NrReq-1:0][1:0]         req_priv_i,
  input  logic [NrReq-1:0][VgeinW-1:0]  req_vgein_i,
  input  logic [NrReq-1:0][31:0]        req_addr_i,
  input  logic [NrReq-1:0][XLEN-1:0]    req_data_i,
  input  logic [NrReq-1:0]              req_we_i,
  input  logic [NrReq-1:0]              req_claim_i,
  output logic [NrReq-1:0]              rsp_valid_o,
  output logic [XLEN-1:0]               rsp_data_o,
  output logic                          rsp_exception_o,
  output logic [1:0]                    imsic_priv_lvl_o,
  output logic [VgeinW-1:0]             imsic_vgein_o,
  output logic [31:0]                   imsic_addr_o,
  output logic [XLEN-1:0]               imsic_data_o,
  output logic                          imsic_we_o,
  output logic                          imsic_claim_o,
  input  logic [XLEN-1:0]               imsic_data_i,
  input  logic                          imsic_exception_i
);

  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

  arb_state_e      state_q, state_d;
  imsic_req_t      cap_q;
  logic [IdxW-1:0] ptr_q, win_q, gnt_idx;
  logic [NrReq-1:0] gnt;
  logic [XLEN-1:0] rsp_data_q;
  logic            rsp_exc_q;
  logic            accept, illegal;

  imsic_arb_rr #(.NrReq(NrReq), .IdxW(IdxW)) u_rr (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign accept  = (state_q == IDLE) && (|req_valid_i);
  assign illegal = cap_q.we & cap_q.claim;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid_i) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q      <= '0;
      ptr_q      <= IdxW'(NrReq - 1);
      win_q      <= '0;
      rsp_data_q <= '0;
      rsp_exc_q  <= 1'b0;
    end else begin
      if (accept) begin
        cap_q.priv  <= req_priv_i[gnt_idx];
        cap_q.vgein <= DefVgeinW'(req_vgein_i[gnt_idx]);
        cap_q.addr  <= req_addr_i[gnt_idx];
        cap_q.data  <= RiscvXlen'(req_data_i[gnt_idx]);
        cap_q.we    <= req_we_i[gnt_idx];
        cap_q.claim <= req_claim_i[gnt_idx];
        ptr_q       <= gnt_idx;
        win_q       <= gnt_idx;
      end
      if (state_q == ISSUE) begin
        rsp_exc_q  <= illegal | imsic_exception_i;
        rsp_data_q <= (illegal | imsic_exception_i | cap_q.we) ? '0 : imsic_data_i;
      end
    end
  end

  // Outputs are gated by rst_i so a reset landing in ISSUE/RESP suppresses strobes immediately.
  always_comb begin
    req_ready_o      = '0;
    rsp_valid_o      = '0;
    rsp_data_o       = '0;
    rsp_exception_o  = 1'b0;
    imsic_priv_lvl_o = '0;
    imsic_vgein_o    = '0;
    imsic_addr_o     = '0;
    imsic_data_o     = '0;
    imsic_we_o       = 1'b0;
    imsic_claim_o    = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: req_ready_o = gnt;
        ISSUE: begin
          imsic_priv_lvl_o = cap_q.priv;
          imsic_vgein_o    = VgeinW'(cap_q.vgein);
          imsic_addr_o     = cap_q.addr;
          imsic_data_o     = XLEN'(cap_q.data);
          imsic_we_o       = cap_q.we & ~cap_q.claim;
          imsic_claim_o    = cap_q.claim & ~cap_q.we;
        end
        RESP: begin
          rsp_valid_o[win_q] = 1'b1;
          rsp_data_o         = rsp_data_q;
          rsp_exception_o    = rsp_exc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imsic_access_arbiter.sv
// Self-checking bench for imsic_access_arbiter: vector table, scoreboard, corner sequences.
module tb_imsic_access_arbiter;

  localparam int unsigned NrReq  = 2;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned VgeinW = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NrReq-1:0]             req_valid, req_ready;
  logic [NrReq-1:0][1:0]        req_priv;
  logic [NrReq-1:0][VgeinW-1:0] req_vgein;
  logic [NrReq-1:0][31:0]       req_addr;
  logic [NrReq-1:0][XLEN-1:0]   req_data;
  logic [NrReq-1:0]             req_we, req_claim;
  logic [NrReq-1:0]             rsp_valid;
  logic [XLEN-1:0]              rsp_data;
  logic                         rsp_exc;
  logic [1:0]                   imsic_priv;
  logic [VgeinW-1:0]            imsic_vgein;
  logic [31:0]                  imsic_addr;
  logic [XLEN-1:0]              imsic_wdata, imsic_rdata;
  logic                         imsic_we, imsic_claim, imsic_exc;

  always #5 clk = ~clk;

  imsic_access_arbiter #(.NrReq(NrReq), .XLEN(XLEN), .VgeinW(VgeinW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_priv_i        (req_priv),
    .req_vgein_i       (req_vgein),
    .req_addr_i        (req_addr),
    .req_data_i        (req_data),
    .req_we_i          (req_we),
    .req_claim_i       (req_claim),
    .rsp_valid_o       (rsp_valid),
    .rsp_data_o        (rsp_data),
    .rsp_exception_o   (rsp_exc),
    .imsic_priv_lvl_o  (imsic_priv),
    .imsic_vgein_o     (imsic_vgein),
    .imsic_addr_o      (imsic_addr),
    .imsic_data_o      (imsic_wdata),
    .imsic_we_o        (imsic_we),
    .imsic_claim_o     (imsic_claim),
    .imsic_data_i      (imsic_rdata),
    .imsic_exception_i (imsic_exc)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] data;
    logic        exc;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    int unsigned r;
    logic [1:0]  priv;
    logic [3:0]  vgein;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        we, claim;
    logic [63:0] imsic_d;
    logic        imsic_e;
    logic        exp_we, exp_claim;
    logic [63:0] exp_data;
    logic        exp_exc;
  } vec_t;
  vec_t vecs[6];

  // Response monitor: every rsp_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.valid));
        check("rsp_data", rsp_data, e.data);
        check("rsp_exc", 64'(rsp_exc), 64'(e.exc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    logic [1:0] oh;
    rsp_t e;
    oh = 2'b01 << v.r;
    req_priv[v.r]  = v.priv;
    req_vgein[v.r] = v.vgein;
    req_addr[v.r]  = v.addr;
    req_data[v.r]  = v.wdata;
    req_we[v.r]    = v.we;
    req_claim[v.r] = v.claim;
    imsic_rdata    = v.imsic_d;
    imsic_exc      = v.imsic_e;
    req_valid      = oh;
    wait_ready(ok);
    if (ok) begin
      check("ready_onehot", 64'(req_ready), 64'(oh));
      e.valid = oh; e.data = v.exp_data; e.exc = v.exp_exc;
      sb.push_back(e);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check("issue_addr", 64'(imsic_addr), 64'(v.addr));
      check("issue_wdata", imsic_wdata, v.wdata);
      check("issue_priv", 64'(imsic_priv), 64'(v.priv));
      check("issue_vgein", 64'(imsic_vgein), 64'(v.vgein));
      check("issue_we", 64'(imsic_we), 64'(v.exp_we));
      check("issue_claim", 64'(imsic_claim), 64'(v.exp_claim));
      @(negedge clk);
      check("resp_imsic_we_low", 64'(imsic_we), 64'd0);
      check("resp_imsic_addr_low", 64'(imsic_addr), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_imsic_we"}, 64'(imsic_we), 64'd0);
    check({tag, "_imsic_addr"}, 64'(imsic_addr), 64'd0);
    check({tag, "_rsp_data"}, rsp_data, 64'd0);
  endtask

  initial begin
    int          acc_cyc[$];
    logic [1:0]  acc_who[$];
    bit          ok;
    rsp_t        e;

    //         r  priv vg addr        wdata  we claim imsic_d                imsic_e we claim exp_data               exp_exc
    vecs[0] = '{0, 2'd3, 4'd0, 32'h70,  64'h0, 0, 0, 64'hABCD,               0, 0, 0, 64'hABCD,               0};
    vecs[1] = '{1, 2'd3, 4'd0, 32'h0,   64'h0, 0, 1, 64'h1234,               1, 0, 1, 64'h0,                  1};
    vecs[2] = '{0, 2'd1, 4'd2, 32'h40,  64'h5, 1, 0, 64'hFFFF,               0, 1, 0, 64'h0,                  0};
    vecs[3] = '{1, 2'd3, 4'd1, 32'h80,  64'h9, 1, 1, 64'h77,                 0, 0, 0, 64'h0,                  1};
    vecs[4] = '{1, 2'd1, 4'd3, 32'hFF0, 64'h0, 0, 0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 64'hDEAD_BEEF_0000_0001, 0};
    vecs[5] = '{0, 2'd2, 4'd2, 32'h70,  64'h0, 0, 1, 64'h55,                 0, 0, 1, 64'h55,                 0};

    rst = 1'b1; req_valid = '0; req_priv = '0; req_vgein = '0; req_addr = '0;
    req_data = '0; req_we = '0; req_claim = '0; imsic_rdata = '0; imsic_exc = 1'b0;

    repeat (3) @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk); #1 req_valid = '0; rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention from reset exit: expect alternating grants every 3 cycles.
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_we = '0; req_claim = '0;
    imsic_rdata = 64'h99; imsic_exc = 1'b0;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        acc_cyc.push_back(c);
        acc_who.push_back(req_ready);
        e.valid = req_ready; e.data = 64'h99; e.exc = 1'b0;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk); #1;
    check("contention_accepts", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() >= 4) begin
      check("contention_first_cyc", 64'(acc_cyc[0]), 64'd0);
      check("contention_g0", 64'(acc_who[0]), 64'b01);
      check("contention_g1", 64'(acc_who[1]), 64'b10);
      check("contention_g2", 64'(acc_who[2]), 64'b01);
      check("contention_g3", 64'(acc_who[3]), 64'b10);
      check("contention_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
      check("contention_gap3", 64'(acc_cyc[3] - acc_cyc[2]), 64'd3);
    end

    // Reset landing in ISSUE aborts a write from req0; req0 must still win first afterwards.
    req_addr[0] = 32'h44; req_data[0] = 64'h7; req_we[0] = 1'b1;
    req_valid = 2'b01;
    wait_ready(ok);
    if (ok) begin
      @(posedge clk); #1 rst = 1'b1; req_valid = 2'b11;
      @(negedge clk);
      check_all_zero("reset_in_issue");
      @(negedge clk);
      check_all_zero("reset_after_issue");
      @(posedge clk); #1 rst = 1'b0;
      req_we[0] = 1'b0; imsic_rdata = 64'h42;
      @(negedge clk);
      check("post_reset_winner", 64'(req_ready), 64'b01);
      e.valid = 2'b01; e.data = 64'h42; e.exc = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(posedge clk);
    end

    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
